// File: rtl/bsg_sync_gray_decode_if.sv
// Bundle of signals between a gray-pointer synchronizer consumer and the decoder.
// Ports (decoder-side view, modport slave):
//   gray_i   in   width_p  gray pointer from a two-flop synchronizer
//   bin_o    out  width_p  registered binary equivalent of the last sample
//   bin_v_o  out  1        one-cycle pulse when the sample changed
//   delta_o  out  width_p  (new_bin - old_bin) mod 2^width_p, valid with bin_v_o
//   primed_o out  1        first post-reset sample has been captured
//   err_o    out  1        sticky illegal-transition flag (0 unless checker built)
// The master modport is the opposite view, used by whoever drives gray_i.
interface bsg_sync_gray_decode_if #(
  parameter int unsigned width_p = 16
) ();

  logic [width_p-1:0] gray_i;
  logic [width_p-1:0] bin_o;
  logic               bin_v_o;
  logic [width_p-1:0] delta_o;
  logic               primed_o;
  logic               err_o;

  modport master (
    output gray_i,
    input  bin_o,
    input  bin_v_o,
    input  delta_o,
    input  primed_o,
    input  err_o
  );

  modport slave (
    input  gray_i,
    output bin_o,
    output bin_v_o,
    output delta_o,
    output primed_o,
    output err_o
  );

endinterface

// File: rtl/bsg_sync_gray_decode.sv
// Gray-pointer decoder for the receive side of a two-flop synchronizer.
// Converts each sampled gray pointer to binary, flags samples that differ from
// the previous one and reports the forward distance moved (mod 2^width_p).
// All outputs are registered; there is no back-pressure and no sample is dropped.
//
// Ports:
//   clk_i    in  1   sole clock (the synchronized domain)
//   reset_i  in  1   synchronous reset, active-high
//   dec_if   slave modport of bsg_sync_gray_decode_if (gray_i in; bin_o, bin_v_o,
//            delta_o, primed_o, err_o out)
//
// Configuration:
//   BSG_SYNC_GRAY_DECODE_CHECK_EN  when defined, builds a checker that sets the
//   sticky err_o whenever more than one gray bit changes between samples.
//   When undefined, err_o is constant 0.
module bsg_sync_gray_decode #(
  parameter int unsigned width_p = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bsg_sync_gray_decode_if.slave     dec_if
);

  if (width_p < 2 || width_p > 32) begin : g_bad_width
    $error("bsg_sync_gray_decode: width_p must be in 2..32");
  end

  typedef enum logic {
    StPrime,
    StTrack
  } state_e;

  // Prefix XOR from the MSB down.
  function automatic logic [width_p-1:0] g2b(input logic [width_p-1:0] g);
    logic [width_p-1:0] b;
    b = '0;
    b[width_p-1] = g[width_p-1];
    for (int k = int'(width_p) - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  state_e             r_state,     w_state;
  logic [width_p-1:0] r_gray_prev, w_gray_prev;
  logic [width_p-1:0] r_bin,       w_bin;
  logic               r_bin_v,     w_bin_v;
  logic [width_p-1:0] r_delta,     w_delta;
  logic               r_primed,    w_primed;

  logic [width_p-1:0] w_gray;
  logic [width_p-1:0] w_gray_bin;
  logic               w_changed;

  assign w_gray     = dec_if.gray_i;
  assign w_gray_bin = g2b(w_gray);
  assign w_changed  = (w_gray != r_gray_prev);

`ifdef BSG_SYNC_GRAY_DECODE_CHECK_EN
  logic               r_err, w_err;
  logic [width_p-1:0] w_gray_diff;
  logic               w_multi_flip;

  assign w_gray_diff  = w_gray ^ r_gray_prev;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi_flip = ((w_gray_diff & (w_gray_diff - 1'b1)) != '0);
`endif

  always_comb begin
    w_state     = r_state;
    w_gray_prev = r_gray_prev;
    w_bin       = r_bin;
    w_bin_v     = 1'b0;
    w_delta     = '0;
    w_primed    = r_primed;
`ifdef BSG_SYNC_GRAY_DECODE_CHECK_EN
    w_err       = r_err;
`endif
    unique case (r_state)
      StPrime: begin
        // First sample only seeds history; no change or error can be inferred.
        w_gray_prev = w_gray;
        w_bin       = w_gray_bin;
        w_primed    = 1'b1;
        w_state     = StTrack;
      end
      StTrack: begin
        w_gray_prev = w_gray;
        w_bin       = w_gray_bin;
        w_bin_v     = w_changed;
        w_delta     = w_changed ? (w_gray_bin - r_bin) : '0;
`ifdef BSG_SYNC_GRAY_DECODE_CHECK_EN
        w_err       = r_err | w_multi_flip;
`endif
      end
      default: begin
        w_state = StPrime;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= StPrime;
      r_gray_prev <= '0;
      r_bin       <= '0;
      r_bin_v     <= 1'b0;
      r_delta     <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_gray_prev <= w_gray_prev;
      r_bin       <= w_bin;
      r_bin_v     <= w_bin_v;
      r_delta     <= w_delta;
      r_primed    <= w_primed;
    end
  end

`ifdef BSG_SYNC_GRAY_DECODE_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end

  assign dec_if.err_o = r_err;
`else
  assign dec_if.err_o = 1'b0;
`endif

  assign dec_if.bin_o    = r_bin;
  assign dec_if.bin_v_o  = r_bin_v;
  assign dec_if.delta_o  = r_delta;
  assign dec_if.primed_o = r_primed;

endmodule

// File: tb/tb_bsg_sync_gray_decode.sv
// Self-checking bench for bsg_sync_gray_decode at width_p=4: directed scenarios
// with literal expectations, then randomized gray steps with occasional resets,
// all checked every cycle against a behavioural model.
module tb_bsg_sync_gray_decode;

  localparam int unsigned W    = 4;
  localparam int unsigned Mask = (1 << W) - 1;
`ifdef BSG_SYNC_GRAY_DECODE_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic clk;
  logic reset_i;

  bsg_sync_gray_decode_if #(.width_p(W)) dec_if ();

  bsg_sync_gray_decode #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .dec_if  (dec_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  bit cmp_en;

  // Behavioural model state.
  bit          m_have_hist;
  int unsigned m_prev_gray;
  int unsigned m_bin;
  bit          m_v;
  int unsigned m_delta;
  bit          m_primed;
  bit          m_err;

  function automatic int unsigned to_bin(input int unsigned g);
    int unsigned b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
    return b & Mask;
  endfunction

  function automatic int unsigned to_gray(input int unsigned b);
    return (b ^ (b >> 1)) & Mask;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int unsigned g, nb;
    g = 32'(dec_if.gray_i);
    if (reset_i) begin
      m_have_hist <= 1'b0;
      m_prev_gray <= 0;
      m_bin       <= 0;
      m_v         <= 1'b0;
      m_delta     <= 0;
      m_primed    <= 1'b0;
      m_err       <= 1'b0;
    end else begin
      nb = to_bin(g);
      m_bin       <= nb;
      m_prev_gray <= g;
      m_primed    <= 1'b1;
      m_have_hist <= 1'b1;
      if (m_have_hist && g != m_prev_gray) begin
        m_v     <= 1'b1;
        m_delta <= (nb + (1 << W) - m_bin) % (1 << W);
        if (CheckEn && $countones(g ^ m_prev_gray) > 1) m_err <= 1'b1;
      end else begin
        m_v     <= 1'b0;
        m_delta <= 0;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("bin_o",    32'(dec_if.bin_o),    m_bin);
      check("bin_v_o",  32'(dec_if.bin_v_o),  32'(m_v));
      check("delta_o",  32'(dec_if.delta_o),  m_delta);
      check("primed_o", 32'(dec_if.primed_o), 32'(m_primed));
      check("err_o",    32'(dec_if.err_o),    32'(m_err));
    end
  end

  // Drive one cycle's inputs and return at the next falling edge.
  task automatic cyc(input int unsigned g, input bit r);
    dec_if.gray_i = W'(g);
    reset_i       = r;
    @(negedge clk);
  endtask

  task automatic pin(input string name, input int unsigned bin, input bit v,
                     input int unsigned delta, input bit err);
    check({name, "_bin"},       32'(dec_if.bin_o),   bin);
    check({name, "_v"},         32'(dec_if.bin_v_o), 32'(v));
    check({name, "_delta"},     32'(dec_if.delta_o), delta);
    check({name, "_err"},       32'(dec_if.err_o),   32'(err));
    check({name, "_model_bin"}, m_bin,               bin);
    check({name, "_model_dlt"}, m_delta,             delta);
  endtask

  initial begin
    int unsigned g;
    tests  = 0;
    fails  = 0;
    cmp_en = 1'b0;
    dec_if.gray_i = '0;
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    pin("reset", 0, 1'b0, 0, 1'b0);
    check("reset_primed", 32'(dec_if.primed_o), 0);

    // Prime with 0011 -> bin 0010, no pulse.
    cyc(4'b0011, 1'b0);
    pin("prime", 2, 1'b0, 0, 1'b0);
    check("prime_primed", 32'(dec_if.primed_o), 1);
    cyc(4'b0011, 1'b0);
    pin("prime_hold", 2, 1'b0, 0, 1'b0);

    // Counting sequence: back-to-back pulses.
    cyc(4'b0000, 1'b0);
    pin("cnt0", 0, 1'b1, 14, 1'b0);
    cyc(4'b0001, 1'b0);
    pin("cnt1", 1, 1'b1, 1, 1'b0);
    cyc(4'b0011, 1'b0);
    pin("cnt2", 2, 1'b1, 1, 1'b0);
    cyc(4'b0010, 1'b0);
    pin("cnt3", 3, 1'b1, 1, 1'b0);

    // Legal walk up to binary 15, then wrap to 0.
    for (int b = 4; b <= 15; b++) cyc(to_gray(b), 1'b0);
    pin("at15", 15, 1'b1, 1, 1'b0);
    cyc(4'b0000, 1'b0);
    pin("wrap", 0, 1'b1, 1, 1'b0);

    // Illegal two-bit jump.
    cyc(4'b0011, 1'b0);
    pin("jump", 2, 1'b1, 2, CheckEn);
    cyc(4'b0011, 1'b0);
    pin("jump_sticky", 2, 1'b0, 0, CheckEn);

    // Reset mid-operation, then re-prime at 0110 -> 0100.
    cyc(4'b0111, 1'b0);
    cyc(4'b0110, 1'b0);
    cyc(4'b0110, 1'b1);
    pin("midreset", 0, 1'b0, 0, 1'b0);
    check("midreset_primed", 32'(dec_if.primed_o), 0);
    cyc(4'b0110, 1'b0);
    pin("reprime", 4, 1'b0, 0, 1'b0);
    check("reprime_primed", 32'(dec_if.primed_o), 1);

    // Hold constant for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0110, 1'b0);
      check("hold_v",     32'(dec_if.bin_v_o), 0);
      check("hold_delta", 32'(dec_if.delta_o), 0);
    end

    // Randomized: mostly single-bit steps, some holds, some arbitrary jumps,
    // rare resets.
    g = 32'b0110;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 65)      g = g ^ (1 << $urandom_range(0, W - 1));
      else if (r < 85) g = g;
      else             g = $urandom_range(0, Mask);
      cyc(g, ($urandom_range(0, 99) < 2));
    end

    cyc(g, 1'b0);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
